motor_pwm: RTL and testbench
============================

Name: motor_pwm

Overview:
- Speed-command-to-PWM block for a DC motor driver. Takes a 4-bit speed level from board switches and produces one PWM output whose duty cycle is proportional to the level, from 0 % to 100 %.
- Drives an 8-LED bar graph that shows the level currently applied.
- Sits between the switch inputs and the motor driver pin.

Parameters:
- PRESCALE, 1, number of clk cycles per PWM counter tick (≥1); sets PWM frequency = f_clk/(255·PRESCALE).
- RAMP_EN, 0, 1 = applied level slews by at most ±1 per PWM period (soft start/stop); 0 = applied level jumps directly to the command.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- entrada  input  4  asynchronous speed command, 0 = stop, 15 = full speed.
- pwm  output  1  registered PWM drive to motor.
- LED  output  8  registered bar-graph of applied level.

Behaviour:
- One clock; reset is synchronous and active-high (clk, rst).
- Reset values: sync flops 0, prescale counter 0, period counter cnt 0, applied level lvl 0, pwm 0, LED 8'h00. Reset asserted mid-period aborts immediately; no partial pulse after the reset edge.

Input path:
- entrada passes through a 2-flop synchronizer, giving cmd.
- cmd is valid 2 clocks after an entrada change.

Prescaler:
- tick is asserted 1 cycle in every PRESCALE cycles.
- With PRESCALE=1, tick is constantly 1.

Period counter:
- cnt is 8 bits, counts 0..254 on tick, then wraps 254→0.
- Period = 255 ticks. Value 255 is never reached.

Level update:
- Occurs only at period boundary, i.e. the clock where tick=1 and cnt=254, so the new level takes effect from cnt=0.
- RAMP_EN=0: lvl <= cmd.
- RAMP_EN=1: lvl <= lvl+1 if cmd>lvl; lvl-1 if cmd<lvl; otherwise unchanged.
- A command change mid-period never alters the current period.

Duty:
- duty = lvl·17, 8-bit unsigned, range 0..255.
- pwm <= (cnt < duty), registered, so pwm lags cnt by one clock.
- lvl=0: pwm constantly 0. lvl=15: duty 255 > 254, pwm constantly 1 (100 %, no glitch at wrap).
- High time per period = lvl·17 ticks.

LED:
- LED <= thermometer code of n = (lvl+1)>>1, i.e. LED[i]=1 for i<n.
- Examples: lvl 0→00, 1→01, 5→07, 14→7F, 15→FF.
- LED updates one clock after lvl.

Other rules:
- Latency from an entrada change to a new duty is 2 clocks plus the wait to the next period boundary, plus 1 clock for pwm/LED.
- Repeated identical commands cause no effect; entrada glitches shorter than one clock are either ignored or sampled — no metastability reaches the logic.

Test Plan:
1. PRESCALE=1, RAMP_EN=0. Assert rst for 3 clocks with entrada=4'hA → pwm=0 and LED=00 throughout reset and on the first clock after release; then the first level update at cnt wrap sets LED=1F.
2. entrada=0, run 3 periods (765 clk) → pwm never 1, LED=00. Then entrada=15 → after the next boundary, pwm stays 1 for ≥3 full periods with no low cycle at the wrap; LED=FF.
3. entrada=5 steady → each 255-clk period has exactly 85 consecutive high clocks starting at cnt=0, LED=07. entrada=14 → 238 high clocks, LED=7F.
4. Change entrada from 5 to 10 at cnt≈100 → the current period still has 85 high clocks; the next period has 170 high clocks; LED goes 07→1F at the boundary.
5. RAMP_EN=1, lvl=0, entrada=15 → lvl rises 1 per period: high times 17, 34, …, 255 over 15 periods. Then entrada=0 → ramps down symmetrically.
6. PRESCALE=4, entrada=3 → period = 1020 clk, high time = 204 clk. Assert rst mid-high → pwm=0 on the next clock; counting restarts from cnt=0.

Source files
------------

// File: rtl/motor_pwm.sv
// rtl/motor_pwm.sv - speed-level-to-PWM drive for a DC motor with LED bar graph
//
// Ports:
//   clk      system clock, all logic on the rising edge
//   rst      synchronous active-high reset
//   entrada  4-bit asynchronous speed command (0 = stop, 15 = full speed)
//   pwm      registered PWM drive, duty = lvl*17/255
//   LED      registered thermometer bar graph of the applied level
//
// Parameters:
//   PRESCALE clk cycles per PWM counter tick (>= 1)
//   RAMP_EN  1 = applied level moves at most one step per PWM period

module motor_pwm #(
    parameter int PRESCALE = 1,
    parameter bit RAMP_EN  = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] entrada,
    output logic       pwm,
    output logic [7:0] LED
);

    localparam int            PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [7:0]    CNT_LAST = 8'd254;

    logic [3:0]    sync1;
    logic [3:0]    cmd;
    logic [PW-1:0] pre_cnt;
    logic          tick;
    logic [7:0]    cnt;
    logic          boundary;
    logic [3:0]    lvl;
    logic [3:0]    lvl_next;
    logic [7:0]    duty;
    logic [4:0]    lvl_inc;
    logic [3:0]    n_on;
    logic [7:0]    bar;

    // Two-flop synchronizer; the switches are asynchronous to clk.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 4'd0;
            cmd   <= 4'd0;
        end else begin
            sync1 <= entrada;
            cmd   <= sync1;
        end
    end

    // With PRESCALE=1 PRE_LAST is 0, so pre_cnt sits at 0 and tick is always high.
    assign tick = (pre_cnt == PRE_LAST);

    always_ff @(posedge clk) begin
        if (rst || tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

    // 255-tick period: 0..254. Stopping short of 255 lets duty=255 mean 100 %.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= 8'd0;
        end else if (tick) begin
            cnt <= (cnt == CNT_LAST) ? 8'd0 : cnt + 8'd1;
        end
    end

    assign boundary = tick && (cnt == CNT_LAST);

    // Level only changes on the last tick of a period, so a running period
    // always completes with the level it started with.
    always_comb begin
        lvl_next = lvl;
        if (boundary) begin
            if (!RAMP_EN) begin
                lvl_next = cmd;
            end else if (cmd > lvl) begin
                lvl_next = lvl + 4'd1;
            end else if (cmd < lvl) begin
                lvl_next = lvl - 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lvl <= 4'd0;
        end else begin
            lvl <= lvl_next;
        end
    end

    // lvl*17 = (lvl<<4) + lvl; 15*17 = 255 fits exactly in 8 bits.
    assign duty = {lvl, 4'b0000} + {4'b0000, lvl};

    // Bar length is the level rounded up to half-steps: (lvl+1)>>1, 0..8 LEDs.
    assign lvl_inc = {1'b0, lvl} + 5'd1;
    assign n_on    = lvl_inc[4:1];

    always_comb begin
        bar = 8'h00;
        for (int i = 0; i < 8; i++) begin
            bar[i] = (4'(i) < n_on);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pwm <= 1'b0;
            LED <= 8'h00;
        end else begin
            pwm <= (cnt < duty);
            LED <= bar;
        end
    end

endmodule

// File: tb/tb_motor_pwm.sv
// tb/tb_motor_pwm.sv - self-checking bench for motor_pwm in three configurations

module tb_motor_pwm;

    localparam int P0 = 1;
    localparam int P1 = 1;
    localparam int P2 = 4;

    logic       clk = 1'b0;
    logic [2:0] rst_v;
    logic [3:0] ent   [3];
    logic [2:0] pwm_v;
    logic [7:0] led_v [3];

    int tests = 0;
    int fails = 0;

    int pr [3] = '{P0, P1, P2};
    int ra [3] = '{0, 1, 0};

    // Reference model state
    int         mn   [3];
    int         mh1  [3];
    int         mh2  [3];
    int         mlvl [3];
    int         mper [3];
    logic       epwm [3];
    logic [7:0] eled [3];

    // Per-period high-time measurement
    int cur_per [3] = '{-2, -2, -2};
    int plen    [3] = '{0, 0, 0};
    int phi     [3] = '{0, 0, 0};
    int q0 [$];
    int q1 [$];
    int q2 [$];

    always #5 clk = ~clk;

    motor_pwm #(.PRESCALE(P0), .RAMP_EN(1'b0)) u_a (
        .clk(clk), .rst(rst_v[0]), .entrada(ent[0]), .pwm(pwm_v[0]), .LED(led_v[0])
    );
    motor_pwm #(.PRESCALE(P1), .RAMP_EN(1'b1)) u_r (
        .clk(clk), .rst(rst_v[1]), .entrada(ent[1]), .pwm(pwm_v[1]), .LED(led_v[1])
    );
    motor_pwm #(.PRESCALE(P2), .RAMP_EN(1'b0)) u_p (
        .clk(clk), .rst(rst_v[2]), .entrada(ent[2]), .pwm(pwm_v[2]), .LED(led_v[2])
    );

    // Behavioural model: edge n after reset is tick n/P, period (n/P)/255,
    // counter position (n/P)%255; the command seen is the input two edges back.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst_v[i]) begin
                mn[i] = 0; mh1[i] = 0; mh2[i] = 0; mlvl[i] = 0;
                mper[i] = -1; epwm[i] = 1'b0; eled[i] = 8'h00;
            end else begin
                int c;
                c = (mn[i] / pr[i]) % 255;
                mper[i] = (mn[i] / pr[i]) / 255;
                epwm[i] = (c < mlvl[i] * 17);
                eled[i] = 8'((32'd1 << ((mlvl[i] + 1) / 2)) - 1);
                if ((mn[i] % pr[i]) == pr[i] - 1 && c == 254) begin
                    if (ra[i] == 0)            mlvl[i] = mh2[i];
                    else if (mh2[i] > mlvl[i]) mlvl[i] = mlvl[i] + 1;
                    else if (mh2[i] < mlvl[i]) mlvl[i] = mlvl[i] - 1;
                end
                mh2[i] = mh1[i];
                mh1[i] = int'(ent[i]);
                mn[i]  = mn[i] + 1;
            end
        end
    end

    // Advance one clock, sample at the falling edge, record completed periods.
    task automatic step();
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            if (mper[i] != cur_per[i]) begin
                if (plen[i] == 255 * pr[i]) begin
                    case (i)
                        0:       q0.push_back(phi[i]);
                        1:       q1.push_back(phi[i]);
                        default: q2.push_back(phi[i]);
                    endcase
                end
                cur_per[i] = mper[i];
                plen[i] = 0;
                phi[i] = 0;
            end
            plen[i]++;
            if (pwm_v[i] === 1'b1) phi[i]++;
        end
    endtask

    task automatic test_reset();
        int waited;
        rst_v[0] = 1'b1;
        ent[0] = 4'hA;
        for (int k = 0; k < 3; k++) begin
            step();
            tests++;
            if (pwm_v[0] !== 1'b0 || led_v[0] !== 8'h00) begin
                fails++;
                $display("FAIL reset_hold pwm=%b led=%h expected pwm=0 led=00", pwm_v[0], led_v[0]);
            end
        end
        rst_v[0] = 1'b0;
        step();
        tests++;
        if (pwm_v[0] !== 1'b0 || led_v[0] !== 8'h00) begin
            fails++;
            $display("FAIL reset_release pwm=%b led=%h expected pwm=0 led=00", pwm_v[0], led_v[0]);
        end
        waited = 0;
        while (led_v[0] === 8'h00 && waited < 400) begin
            step();
            waited++;
            tests++;
            if (pwm_v[0] !== epwm[0] || led_v[0] !== eled[0]) begin
                fails++;
                $display("FAIL reset_model pwm=%b led=%h expected pwm=%b led=%h", pwm_v[0], led_v[0], epwm[0], eled[0]);
            end
        end
        tests++;
        if (led_v[0] !== 8'h1F) begin
            fails++;
            $display("FAIL reset_first_led led=%h expected 1f", led_v[0]);
        end
        tests++;
        if (waited != 255) begin
            fails++;
            $display("FAIL reset_first_update clocks=%0d expected 255", waited);
        end
    endtask

    task automatic test_stop_full();
        int hc;
        int lc;
        ent[0] = 4'h0;
        for (int k = 0; k < 300; k++) begin
            step();
            tests++;
            if (pwm_v[0] !== epwm[0] || led_v[0] !== eled[0]) begin
                fails++;
                $display("FAIL stop_model pwm=%b led=%h expected pwm=%b led=%h", pwm_v[0], led_v[0], epwm[0], eled[0]);
            end
        end
        hc = 0;
        for (int k = 0; k < 765; k++) begin
            step();
            if (pwm_v[0] !== 1'b0) hc++;
        end
        tests++;
        if (hc != 0 || led_v[0] !== 8'h00) begin
            fails++;
            $display("FAIL stop_level high_clocks=%0d led=%h expected 0 and 00", hc, led_v[0]);
        end
        ent[0] = 4'hF;
        for (int k = 0; k < 300; k++) begin
            step();
            tests++;
            if (pwm_v[0] !== epwm[0] || led_v[0] !== eled[0]) begin
                fails++;
                $display("FAIL full_model pwm=%b led=%h expected pwm=%b led=%h", pwm_v[0], led_v[0], epwm[0], eled[0]);
            end
        end
        lc = 0;
        for (int k = 0; k < 765; k++) begin
            step();
            if (pwm_v[0] !== 1'b1) lc++;
        end
        tests++;
        if (lc != 0 || led_v[0] !== 8'hFF) begin
            fails++;
            $display("FAIL full_level low_clocks=%0d led=%h expected 0 and ff", lc, led_v[0]);
        end
    endtask

    task automatic test_duty();
        int lvls [5];
        int exp_led;
        lvls[0] = 5;
        lvls[1] = 14;
        for (int j = 2; j < 5; j++) lvls[j] = $urandom_range(0, 15);
        for (int j = 0; j < 5; j++) begin
            ent[0] = 4'(lvls[j]);
            if (j == 0)      exp_led = 8'h07;
            else if (j == 1) exp_led = 8'h7F;
            else             exp_led = (1 << ((lvls[j] + 1) / 2)) - 1;
            for (int k = 0; k < 300; k++) begin
                step();
                tests++;
                if (pwm_v[0] !== epwm[0] || led_v[0] !== eled[0]) begin
                    fails++;
                    $display("FAIL duty_model lvl=%0d pwm=%b led=%h expected pwm=%b led=%h", lvls[j], pwm_v[0], led_v[0], epwm[0], eled[0]);
                end
            end
            q0.delete();
            for (int k = 0; k < 765; k++) step();
            tests++;
            if (q0.size() < 2) begin
                fails++;
                $display("FAIL duty_periods lvl=%0d periods=%0d expected >=2", lvls[j], q0.size());
            end
            foreach (q0[k]) begin
                tests++;
                if (q0[k] != lvls[j] * 17) begin
                    fails++;
                    $display("FAIL duty_high lvl=%0d high=%0d expected %0d", lvls[j], q0[k], lvls[j] * 17);
                end
            end
            tests++;
            if (led_v[0] !== 8'(exp_led)) begin
                fails++;
                $display("FAIL duty_led lvl=%0d led=%h expected %h", lvls[j], led_v[0], exp_led);
            end
        end
    endtask

    task automatic test_mid_change();
        int w;
        ent[0] = 4'h5;
        for (int k = 0; k < 600; k++) step();
        q0.delete();
        w = 0;
        while (q0.size() < 1 && w < 600) begin step(); w++; end
        for (int k = 0; k < 100; k++) step();
        tests++;
        if (led_v[0] !== 8'h07) begin
            fails++;
            $display("FAIL mid_led_before led=%h expected 07", led_v[0]);
        end
        ent[0] = 4'hA;
        w = 0;
        while (q0.size() < 2 && w < 600) begin step(); w++; end
        tests++;
        if (q0.size() < 2 || q0[1] != 85) begin
            fails++;
            $display("FAIL mid_current_period high=%0d expected 85", (q0.size() < 2) ? -1 : q0[1]);
        end
        tests++;
        if (led_v[0] !== 8'h1F) begin
            fails++;
            $display("FAIL mid_led_after led=%h expected 1f", led_v[0]);
        end
        w = 0;
        while (q0.size() < 3 && w < 600) begin step(); w++; end
        tests++;
        if (q0.size() < 3 || q0[2] != 170) begin
            fails++;
            $display("FAIL mid_next_period high=%0d expected 170", (q0.size() < 3) ? -1 : q0[2]);
        end
    endtask

    task automatic test_ramp();
        int w;
        ent[1] = 4'hF;
        q1.delete();
        rst_v[1] = 1'b0;
        w = 0;
        while (q1.size() < 17 && w < 255 * 18) begin
            step();
            w++;
            tests++;
            if (pwm_v[1] !== epwm[1] || led_v[1] !== eled[1]) begin
                fails++;
                $display("FAIL ramp_up_model pwm=%b led=%h expected pwm=%b led=%h", pwm_v[1], led_v[1], epwm[1], eled[1]);
            end
        end
        for (int k = 0; k < 17; k++) begin
            tests++;
            if (k >= q1.size() || q1[k] != ((k < 15) ? k : 15) * 17) begin
                fails++;
                $display("FAIL ramp_up period=%0d high=%0d expected %0d", k, (k < q1.size()) ? q1[k] : -1, ((k < 15) ? k : 15) * 17);
            end
        end
        ent[1] = 4'h0;
        q1.delete();
        w = 0;
        while (q1.size() < 16 && w < 255 * 17) begin
            step();
            w++;
            tests++;
            if (pwm_v[1] !== epwm[1] || led_v[1] !== eled[1]) begin
                fails++;
                $display("FAIL ramp_down_model pwm=%b led=%h expected pwm=%b led=%h", pwm_v[1], led_v[1], epwm[1], eled[1]);
            end
        end
        for (int k = 0; k < 16; k++) begin
            tests++;
            if (k >= q1.size() || q1[k] != (15 - k) * 17) begin
                fails++;
                $display("FAIL ramp_down period=%0d high=%0d expected %0d", k, (k < q1.size()) ? q1[k] : -1, (15 - k) * 17);
            end
        end
    endtask

    task automatic test_prescale();
        int w;
        int exp_hi [3] = '{0, 204, 204};
        ent[2] = 4'h3;
        q2.delete();
        rst_v[2] = 1'b0;
        w = 0;
        while (q2.size() < 3 && w < 1020 * 4) begin
            step();
            w++;
            tests++;
            if (pwm_v[2] !== epwm[2] || led_v[2] !== eled[2]) begin
                fails++;
                $display("FAIL prescale_model pwm=%b led=%h expected pwm=%b led=%h", pwm_v[2], led_v[2], epwm[2], eled[2]);
            end
        end
        for (int k = 0; k < 3; k++) begin
            tests++;
            if (k >= q2.size() || q2[k] != exp_hi[k]) begin
                fails++;
                $display("FAIL prescale_high period=%0d high=%0d expected %0d", k, (k < q2.size()) ? q2[k] : -1, exp_hi[k]);
            end
        end
        w = 0;
        while (pwm_v[2] !== 1'b1 && w < 1100) begin step(); w++; end
        for (int k = 0; k < 50; k++) step();
        rst_v[2] = 1'b1;
        step();
        tests++;
        if (pwm_v[2] !== 1'b0 || led_v[2] !== 8'h00) begin
            fails++;
            $display("FAIL prescale_rst pwm=%b led=%h expected pwm=0 led=00", pwm_v[2], led_v[2]);
        end
        rst_v[2] = 1'b0;
        w = 0;
        do begin
            step();
            w++;
        end while (pwm_v[2] !== 1'b1 && w < 2000);
        tests++;
        if (w != 1021) begin
            fails++;
            $display("FAIL prescale_restart clocks_to_high=%0d expected 1021", w);
        end
    endtask

    initial begin
        rst_v = 3'b111;
        for (int i = 0; i < 3; i++) ent[i] = 4'h0;
        test_reset();
        test_stop_full();
        test_duty();
        test_mid_change();
        test_ramp();
        test_prescale();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
